// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed 7-segment scan driver: double-buffered hex value, programmable
// dwell and dead time, optional leading-zero blanking, registered pin outputs.
module seven_segment_scan_driver #(
  parameter int unsigned NUM_DIGITS          = 4,
  parameter int unsigned CLKS_PER_DIGIT      = 25000,
  parameter int unsigned DEAD_CLKS           = 2,
  parameter bit          SEG_ACTIVE_LOW      = 1'b1,
  parameter bit          DIG_ACTIVE_LOW      = 1'b1,
  parameter bit          BLANK_LEADING_ZEROS = 1'b0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_Dp,
  input  logic                    i_Enable,
  output logic [6:0]              o_Segment,
  output logic                    o_Dp,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Start
);

  localparam int unsigned CntW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0]       CntLast = CntW'(CLKS_PER_DIGIT - 1);
  localparam logic [CntW-1:0]       CntDead = CntW'(DEAD_CLKS);
  localparam logic [DigW-1:0]       DigLast = DigW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SegOff  = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DigOff  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DigW-1:0]         dig_q, dig_d;
  logic [4*NUM_DIGITS-1:0] shadow_value_q, active_value_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    frame_q, frame_d;

  logic                    frame_wrap;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    seen_nonzero;
  logic                    blank;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   dig_onehot;

  // Slot/digit scan counters
  always_comb begin
    frame_wrap = (cnt_q == CntLast) && (dig_q == DigLast);
    cnt_d      = cnt_q + CntW'(1);
    dig_d      = dig_q;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      dig_d = (dig_q == DigLast) ? '0 : dig_q + DigW'(1);
    end
  end

  // lead_zero[d] set when nibbles d..NUM_DIGITS-1 of the active value are all zero
  always_comb begin
    lead_zero    = '0;
    seen_nonzero = 1'b0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      seen_nonzero = seen_nonzero | (active_value_q[4*d +: 4] != 4'h0);
      lead_zero[d] = ~seen_nonzero;
    end
  end

  always_comb begin
    cur_nibble = active_value_q[4*dig_q +: 4];
    cur_dp     = active_dp_q[dig_q];
    blank      = BLANK_LEADING_ZEROS && (dig_q != '0) && lead_zero[dig_q];
    seg_raw    = blank ? 7'h00 : hex_to_seg(cur_nibble);

    seg_d = i_Enable ? (seg_raw ^ SegOff) : SegOff;
    dp_d  = i_Enable ? (cur_dp ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;

    dig_onehot = '0;
    if (i_Enable && (cnt_q >= CntDead)) begin
      dig_onehot[dig_q] = 1'b1;
    end
    dig_en_d = dig_onehot ^ DigOff;
    frame_d  = (cnt_q == '0) && (dig_q == '0);

    // A load coinciding with the frame wrap stays pending for the next boundary
    pending_d = pending_q;
    if (frame_wrap) pending_d = 1'b0;
    if (i_Load)     pending_d = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q          <= '0;
      dig_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      active_value_q <= '0;
      active_dp_q    <= '0;
      pending_q      <= 1'b0;
      seg_q          <= SegOff;
      dp_q           <= SEG_ACTIVE_LOW;
      dig_en_q       <= DigOff;
      frame_q        <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      pending_q <= pending_d;
      if (i_Load) begin
        shadow_value_q <= i_Value;
        shadow_dp_q    <= i_Dp;
      end
      if (frame_wrap && pending_q) begin
        active_value_q <= shadow_value_q;
        active_dp_q    <= shadow_dp_q;
      end
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
      frame_q  <= frame_d;
    end
  end

  assign o_Segment     = seg_q;
  assign o_Dp          = dp_q;
  assign o_Digit_En    = dig_en_q;
  assign o_Frame_Start = frame_q;

endmodule

// File: doc/seven_segment_scan_driver.md
# seven_segment_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode/cathode 7-segment digits sharing one segment bus. Holds a packed hex value in a double-buffered register and scans one digit per slot with a programmable dwell and anti-ghosting dead time. Optional leading-zero blanking and per-digit decimal points. Sits between application logic (counters, UART/debug values) and the board's segment and digit-select pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 1..8)
- CLKS_PER_DIGIT, 25000, clock cycles per digit slot (legal >= DEAD_CLKS+2)
- DEAD_CLKS, 2, cycles at the start of each slot with all digit enables inactive
- SEG_ACTIVE_LOW, 1, 1 = segments/DP lit when driven 0
- DIG_ACTIVE_LOW, 1, 1 = digit enable active when driven 0
- BLANK_LEADING_ZEROS, 0, 1 = suppress leading zero digits

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset; synchronous, active-high
- i_Load  in  1  single-cycle strobe; captures i_Value/i_Dp into shadow buffer
- i_Value  in  4*NUM_DIGITS  packed nibbles; nibble d drives digit d (d=0 least significant)
- i_Dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- i_Enable  in  1  0 = display dark (scan keeps running)
- o_Segment  out  7  segments, bit6=A … bit0=G
- o_Dp  out  1  decimal point of the current digit
- o_Digit_En  out  NUM_DIGITS  one-hot digit select (polarity per DIG_ACTIVE_LOW)
- o_Frame_Start  out  1  one-cycle pulse at the start of each frame (digit 0 slot)

## Operation
- Slot counter 0..CLKS_PER_DIGIT-1; at terminal count it wraps and digit index advances 0→1→…→NUM_DIGITS-1→0. Frame = NUM_DIGITS slots.
- Shadow buffer: on i_Load, shadow <= {i_Value, i_Dp}, pending <= 1. Multiple loads in one frame: last wins.
- Active buffer: at the wrap from digit NUM_DIGITS-1 to 0, if pending then active <= shadow, pending <= 0. A load on that same wrap cycle lands in shadow and is applied at the following frame boundary. No mid-frame tearing.
- Decode (raw, bit6..0): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47. SEG_ACTIVE_LOW inverts segments and DP.
- Blanking (BLANK_LEADING_ZEROS=1): digit d>0 blank if active nibbles d..NUM_DIGITS-1 are all zero; digit 0 never blanked. Blank = all segments off; DP still honoured.
- Segment/DP outputs for digit d change at the first cycle of slot d (inside dead time) and stay stable for the whole slot.
- Digit enable for d: active for counter values DEAD_CLKS..CLKS_PER_DIGIT-1 of slot d, inactive otherwise.
- i_Enable=0: o_Digit_En all inactive, segments/DP off; counter, buffers and o_Frame_Start unaffected.
- Reset: counter 0, digit index 0, active/shadow 0, pending 0, o_Segment/o_Dp at off level (7'h7F / 1 when active-low), o_Digit_En all inactive, o_Frame_Start 0. Reset mid-operation discards pending load.

## Timing
- All outputs registered; one cycle latency from internal counter/index state to pins.
- First edge with i_Rst low = cycle 0. o_Frame_Start high in cycle 1 and every NUM_DIGITS*CLKS_PER_DIGIT cycles thereafter.
- Digit 0 enable first asserts at cycle DEAD_CLKS+1; each digit active CLKS_PER_DIGIT-DEAD_CLKS consecutive cycles, then DEAD_CLKS cycles all-off.
- Load-to-display latency: up to one frame plus one slot start; exactly at the next o_Frame_Start.
- i_Enable change reaches pins in one cycle.

## Test plan
Config NUM_DIGITS=4, CLKS_PER_DIGIT=8, DEAD_CLKS=2, both active-low, unless stated.
- Reset held 3 cycles -> o_Segment=7'h7F, o_Dp=1, o_Digit_En=4'hF, o_Frame_Start=0; after release, o_Frame_Start pulses at cycles 1, 33, 65.
- Load 16'h12AF, i_Dp=4'b0100 -> from next frame: digit0 seg=7'h38 En=4'b1110; digit1 seg=7'h08; digit2 seg=7'h12, o_Dp=0; digit3 seg=7'h4F.
- Load 16'h1111 mid-slot 2, then 16'h2222 in slot 3 -> current frame unchanged; next frame shows all 2s (7'h12); 1s never displayed.
- BLANK_LEADING_ZEROS=1, value 16'h0050 -> digits 3,2 seg=7'h7F; digit1 7'h24; digit0 7'h01. Value 16'h0000 -> only digit0 shows 7'h01.
- Monitor o_Digit_En over 2 frames -> exactly 2 all-inactive cycles between slots, 6 active cycles each, never two digits active; segments never change while an enable is active.
- Load then i_Rst mid-frame before boundary -> pending discarded, display stays 0 after reset; i_Enable=0 -> En=4'hF, seg=7'h7F next cycle, frame pulses continue.
